tmds_encoder_mc: RTL and testbench
==================================

// Module: tmds_encoder_mc
// PURPOSE
//  Multi-channel pipelined TMDS encoder for the HDMI transmitter: encodes CHANNELS lanes per pixel clock.
//  Modes: video (8b/10b DC-balanced), control (2-bit codes), data island (TERC4), video/data guard bands.
//  Sits between the HDMI timing/packet scheduler and the 10:1 serialisers; one 10-bit symbol per lane per clk.
// PARAMETERS
//  CHANNELS  3  number of TMDS lanes (lane 0 carries hsync/vsync)
//  DISP_W    5  width of signed running-disparity counter (range -16..+15; must hold +-8 and +-10 steps)
// PORTS
//  clk      in   1            pixel clock; one clock domain
//  rst_n    in   1            synchronous, active-low reset
//  mode     in   3            pkg_disp::tmds_mode_t: CTRL, VIDEO, DATA, VGB (video guard), DGB (data guard)
//  ctl      in   2*CHANNELS   per-lane control bits; lane 0 = {vsync,hsync}
//  data     in   8*CHANNELS   per-lane video byte, used in VIDEO
//  terc4    in   4*CHANNELS   per-lane TERC4 nibble, used in DATA
//  out      out  10*CHANNELS  per-lane TMDS symbol, bit 0 transmitted first
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all pipeline regs cleared to mode=CTRL, ctl=0; every lane out=10'b1101010100; disparity=0.
//  - Latency: exactly 2 clk from inputs to out; fully pipelined, one symbol/clk, no stalls.
//  - Stage 1 (registered): per lane N1(data), XNOR=(N1>4)|(N1==4 & d0==0); q_m[0]=d0,
//    q_m[i]=q_m[i-1] XOR/XNOR d[i], q_m[8]=~XNOR; also register mode, ctl, terc4.
//  - Stage 2 VIDEO (per lane, signed cnt, N1/N0 over q_m[7:0]):
//    cnt==0 | N1==N0: out={~q8,q8,q8?q[7:0]:~q[7:0]}; cnt+= q8 ? N1-N0 : N0-N1.
//    (cnt>0 & N1>N0)|(cnt<0 & N0>N1): out={1,q8,~q[7:0]}; cnt+= 2*q8 + N0-N1.
//    else: out={0,q8,q[7:0]}; cnt+= -2*~q8 + N1-N0.  Arithmetic sign-extended to DISP_W; no saturation.
//  - Stage 2 CTRL: out=pkg_disp::code[ctl]: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
//  - DATA: out=pkg_disp::terc4[terc4] per lane (16-entry table).
//  - VGB: lanes 0,2 = 1011001100, lane 1 = 0100110011; lanes >=3 = 0100110011.
//  - DGB: lane 0 = terc4[{1,1,vsync,hsync}]; all other lanes = 0100110011.
//  - Disparity: updated only when stage-2 mode==VIDEO; forced to 0 in the cycle any other mode
//    reaches stage 2; first VIDEO symbol after any non-video symbol starts from cnt=0.
//  - Mode change: takes effect on the symbol it accompanies; no blanking/holdover symbols inserted.
//  - Illegal mode encodings: treated as CTRL (out=code[ctl]), disparity cleared.
//  - Reset mid-stream: both pipeline stages and disparity cleared same edge; first post-reset symbols are CTRL 00.
//  - Lanes fully independent; each lane has its own disparity counter.
// STRUCTURE
//  - pkg_disp: tmds_mode_t enum, code[4] control table, terc4[16] table, VGB/DGB guard constants.
//  - Sub-module tmds_dc_balance: one lane of stage 2 (q_m in, mode in, disparity reg, 10-bit out);
//    instantiated CHANNELS times in a generate loop; stage 1 stays in top.
// TESTING
//  - Reset: hold rst_n=0 3 clk, release with mode=CTRL ctl=0 -> every lane out=1101010100 continuously.
//  - VIDEO data=8'h00 on all lanes from cnt=0 -> out seq 10'h100, 10'h3FF, 10'h100 ...; cnt -8, +2, -6.
//  - CTRL sweep ctl=00,01,10,11 on lane 0 -> code table values appear exactly 2 clk later.
//  - DATA terc4=4'h0 -> 1010011100; 4'hD -> 1001110001; DGB with hsync=1,vsync=0 -> lane 0 1001110001, lanes 1,2 0100110011.
//  - VGB -> lanes 0,2 1011001100, lane 1 0100110011; following VIDEO 8'h00 starts at 10'h100 (disparity cleared).
//  - Random VIDEO bursts vs golden model: |cnt|<=10 always; decoded bytes match; rst_n pulse mid-burst -> CTRL 00 next outputs.

Source files
------------

// File: rtl/tmds_encoder_mc_pkg.sv
// Shared definitions for the multi-channel TMDS encoder.
//   tmds_mode_t  : symbol mode carried with each pixel (CTRL/VIDEO/DATA/VGB/DGB)
//   CTL_CODE     : 2-bit control-period symbol table
//   TERC4_TAB    : 16-entry TERC4 data-island symbol table
//   guard bands  : video/data guard-band symbols
//   popcnt8/tmds_qm : helpers for the 8b/9b transition-minimising stage
package tmds_encoder_mc_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL  = 3'd0,
    MODE_VIDEO = 3'd1,
    MODE_DATA  = 3'd2,
    MODE_VGB   = 3'd3,
    MODE_DGB   = 3'd4
  } tmds_mode_t;

  localparam logic [9:0] CTL_CODE [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] VGB_EVEN = 10'b1011001100;  // video guard, lanes 0 and 2
  localparam logic [9:0] GB_OTHER = 10'b0100110011;  // lane 1 VGB, non-zero lanes DGB

  function automatic logic [3:0] popcnt8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  // 8b -> 9b transition-minimised word; bit 8 set means the XOR chain was used.
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       xn;
    logic [8:0] q;
    n1   = popcnt8(d);
    xn   = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return q;
  endfunction

endpackage

// File: rtl/tmds_encoder_mc_if.sv
// Pixel-side bus of the TMDS encoder.
//   mode  : raw 3-bit mode (illegal codes allowed, decoded as CTRL)
//   ctl   : per-lane control bits, lane 0 = {vsync,hsync}
//   data  : per-lane video byte
//   terc4 : per-lane TERC4 nibble
//   out   : per-lane 10-bit TMDS symbol, bit 0 first on the wire
interface tmds_encoder_mc_if #(parameter int CHANNELS = 3);
  logic [2:0]               mode;
  logic [CHANNELS-1:0][1:0] ctl;
  logic [CHANNELS-1:0][7:0] data;
  logic [CHANNELS-1:0][3:0] terc4;
  logic [CHANNELS-1:0][9:0] out;

  modport master (output mode, ctl, data, terc4, input out);
  modport slave  (input mode, ctl, data, terc4, output out);
endinterface

// File: rtl/tmds_encoder_mc_dc_balance.sv
// One lane of the second pipeline stage: DC-balancing for video plus the
// table-driven control/TERC4/guard-band symbols, and the lane's disparity.
//   clk, rst_n : pixel clock, synchronous active-low reset
//   mode_i     : stage-1 registered mode
//   qm_i       : stage-1 transition-minimised word
//   ctl_i      : stage-1 control bits for this lane
//   terc4_i    : stage-1 TERC4 nibble for this lane
//   sym_o      : registered 10-bit symbol
module tmds_encoder_mc_dc_balance
  import tmds_encoder_mc_pkg::*;
#(
  parameter int LANE   = 0,
  parameter int DISP_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode_i,
  input  logic [8:0] qm_i,
  input  logic [1:0] ctl_i,
  input  logic [3:0] terc4_i,
  output logic [9:0] sym_o
);

  localparam logic signed [DISP_W-1:0] TWO = DISP_W'(2);

  logic [9:0]               sym_q, sym_d;
  logic signed [DISP_W-1:0] cnt_q, cnt_d;
  logic [3:0]               n1, n0;
  logic signed [DISP_W-1:0] n1_s, n0_s;
  logic                     q8, cnt_zero, cnt_pos, cnt_neg;

  always_comb begin
    n1       = popcnt8(qm_i[7:0]);
    n0       = 4'd8 - n1;
    n1_s     = DISP_W'(n1);
    n0_s     = DISP_W'(n0);
    q8       = qm_i[8];
    cnt_zero = (cnt_q == '0);
    cnt_neg  = cnt_q[DISP_W-1];
    cnt_pos  = !cnt_zero && !cnt_neg;

    // any non-video symbol clears disparity so the next video run starts at 0
    sym_d = CTL_CODE[ctl_i];
    cnt_d = '0;
    case (mode_i)
      MODE_VIDEO: begin
        if (cnt_zero || (n1 == n0)) begin
          sym_d = {~q8, q8, q8 ? qm_i[7:0] : ~qm_i[7:0]};
          cnt_d = q8 ? (cnt_q + n1_s - n0_s) : (cnt_q + n0_s - n1_s);
        end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
          sym_d = {1'b1, q8, ~qm_i[7:0]};
          cnt_d = cnt_q + (q8 ? TWO : '0) + n0_s - n1_s;
        end else begin
          sym_d = {1'b0, q8, qm_i[7:0]};
          cnt_d = cnt_q - (q8 ? '0 : TWO) + n1_s - n0_s;
        end
      end
      MODE_DATA: sym_d = TERC4_TAB[terc4_i];
      MODE_VGB:  sym_d = (LANE == 0 || LANE == 2) ? VGB_EVEN : GB_OTHER;
      // lane 0 carries {vsync,hsync} as the low bits of the guard nibble
      MODE_DGB:  sym_d = (LANE == 0) ? TERC4_TAB[{2'b11, ctl_i}] : GB_OTHER;
      default:   sym_d = CTL_CODE[ctl_i];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_q <= CTL_CODE[0];
      cnt_q <= '0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-lane pipelined TMDS encoder: 2-clock latency, one symbol per lane per clock.
// Stage 1 (here) builds q_m per lane and registers mode/ctl/terc4; stage 2 is
// one tmds_encoder_mc_dc_balance per lane.
//   clk, rst_n : pixel clock, synchronous active-low reset
//   bus        : slave side of tmds_encoder_mc_if (mode/ctl/data/terc4 in, out out)
module tmds_encoder_mc
  import tmds_encoder_mc_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int DISP_W   = 5
) (
  input logic              clk,
  input logic              rst_n,
  tmds_encoder_mc_if.slave bus
);

  logic [2:0]               mode_q;
  logic [CHANNELS-1:0][1:0] ctl_q;
  logic [CHANNELS-1:0][3:0] terc4_q;
  logic [CHANNELS-1:0][8:0] qm_q, qm_d;
  logic [CHANNELS-1:0][9:0] sym;

  always_comb begin
    for (int l = 0; l < CHANNELS; l++) qm_d[l] = tmds_qm(bus.data[l]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_CTRL;
      ctl_q   <= '0;
      terc4_q <= '0;
      qm_q    <= '0;
    end else begin
      mode_q  <= bus.mode;
      ctl_q   <= bus.ctl;
      terc4_q <= bus.terc4;
      qm_q    <= qm_d;
    end
  end

  for (genvar l = 0; l < CHANNELS; l++) begin : g_lane
    tmds_encoder_mc_dc_balance #(.LANE(l), .DISP_W(DISP_W)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .mode_i  (mode_q),
      .qm_i    (qm_q[l]),
      .ctl_i   (ctl_q[l]),
      .terc4_i (terc4_q[l]),
      .sym_o   (sym[l])
    );
  end

  assign bus.out = sym;

endmodule

// File: tb/tb_tmds_encoder_mc.sv
module tb_tmds_encoder_mc;
  import tmds_encoder_mc_pkg::*;

  localparam int CH = 3;
  localparam logic [9:0] C0 = 10'b1101010100, C1 = 10'b0010101011;
  localparam logic [9:0] C2 = 10'b0101010100, C3 = 10'b1010101011;
  localparam logic [9:0] VA = 10'b1011001100, GB = 10'b0100110011;

  logic clk = 1'b0;
  logic rst_n;
  tmds_encoder_mc_if #(.CHANNELS(CH)) bus ();

  tmds_encoder_mc #(.CHANNELS(CH), .DISP_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                   tag;
    logic [2:0]              m;
    logic [CH-1:0][7:0]      d;
    logic [CH-1:0][9:0]      e;
  } ent_t;

  ent_t       pq[$];
  int         nchk = 0, nbad = 0;
  int         mcnt [CH];
  int         ord  [CH];
  logic [9:0] T4 [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] d, r;
    d    = s[9] ? ~s[7:0] : s[7:0];
    r    = '0;
    r[0] = d[0];
    for (int i = 1; i < 8; i++) r[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return r;
  endfunction

  // Reference encoder for one lane; advances the lane's model disparity.
  task automatic model(input int l, input logic [2:0] m, input logic [1:0] c,
                       input logic [7:0] d, input logic [3:0] t, output logic [9:0] s);
    int n1, a, b;
    logic xn, q8;
    logic [7:0] q;
    s = (c == 2'd0) ? C0 : (c == 2'd1) ? C1 : (c == 2'd2) ? C2 : C3;
    if (m == 3'(MODE_VIDEO)) begin
      n1 = $countones(d);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
      q8 = !xn;
      a = $countones(q);
      b = 8 - a;
      if (mcnt[l] == 0 || a == b) begin
        s = {~q8, q8, q8 ? q : ~q};
        mcnt[l] += q8 ? a - b : b - a;
      end else if ((mcnt[l] > 0 && a > b) || (mcnt[l] < 0 && b > a)) begin
        s = {1'b1, q8, ~q};
        mcnt[l] += 2 * int'(q8) + b - a;
      end else begin
        s = {1'b0, q8, q};
        mcnt[l] += -2 * int'(!q8) + a - b;
      end
    end else begin
      mcnt[l] = 0;
      if (m == 3'(MODE_DATA)) s = T4[t];
      else if (m == 3'(MODE_VGB)) s = (l == 0 || l == 2) ? VA : GB;
      else if (m == 3'(MODE_DGB)) s = (l == 0) ? T4[{2'b11, c}] : GB;
    end
  endtask

  task automatic compare(input ent_t x);
    int ones;
    for (int l = 0; l < CH; l++) begin
      chk($sformatf("%s.l%0d", x.tag, l), 32'(bus.out[l]), 32'(x.e[l]));
      if (x.m == 3'(MODE_VIDEO)) begin
        chk($sformatf("%s.dec%0d", x.tag, l), 32'(dec(bus.out[l])), 32'(x.d[l]));
        ones = $countones(bus.out[l]);
        ord[l] += 2 * ones - 10;
        chk($sformatf("%s.rd%0d", x.tag, l), 32'(ord[l] <= 10 && ord[l] >= -10), 32'd1);
      end else begin
        ord[l] = 0;
      end
    end
  endtask

  // Drive one pixel; compare the symbol launched two clocks earlier.
  task automatic push(input string tag, input logic [2:0] m, input logic [CH-1:0][1:0] c,
                      input logic [CH-1:0][7:0] d, input logic [CH-1:0][3:0] t,
                      input logic [CH-1:0][9:0] e, input bit use_model);
    ent_t x;
    logic [CH-1:0][9:0] me;
    for (int l = 0; l < CH; l++) model(l, m, c[l], d[l], t[l], me[l]);
    bus.mode = m; bus.ctl = c; bus.data = d; bus.terc4 = t;
    x.tag = tag; x.m = m; x.d = d; x.e = use_model ? me : e;
    pq.push_back(x);
    @(posedge clk); #1;
    if (pq.size() >= 2) compare(pq.pop_front());
  endtask

  task automatic do_reset(input int n);
    ent_t x;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst", 32'(bus.out), 32'({C0, C0, C0}));
    end
    pq.delete();
    for (int l = 0; l < CH; l++) begin mcnt[l] = 0; ord[l] = 0; end
    x.tag = "post_rst"; x.m = 3'(MODE_CTRL); x.d = '0; x.e = {C0, C0, C0};
    pq.push_back(x);  // stage 1 holds CTRL 00 after reset
    rst_n = 1'b1;
  endtask

  localparam logic [2:0] MV = 3'(MODE_VIDEO), MC = 3'(MODE_CTRL), MD = 3'(MODE_DATA);
  localparam logic [2:0] MVG = 3'(MODE_VGB), MDG = 3'(MODE_DGB);

  initial begin
    T4 = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
           10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
           10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
           10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    rst_n = 1'b0;
    bus.mode = MC; bus.ctl = '0; bus.data = '0; bus.terc4 = '0;

    do_reset(3);
    push("ctl0a", MC, '0, '0, '0, {C0, C0, C0}, 0);
    push("ctl0b", MC, '0, '0, '0, {C0, C0, C0}, 0);

    // video 0x00 from zero disparity: -8, +2, -6
    push("v00a", MV, '0, '0, '0, {3{10'h100}}, 0);
    push("v00b", MV, '0, '0, '0, {3{10'h3FF}}, 0);
    push("v00c", MV, '0, '0, '0, {3{10'h100}}, 0);
    push("vgb",  MVG, '0, '0, '0, {VA, GB, VA}, 0);
    push("v_after_vgb", MV, '0, '0, '0, {3{10'h100}}, 0);

    push("ctl00", MC, {2'b00, 2'b00, 2'b00}, '0, '0, {C0, C0, C0}, 0);
    push("ctl01", MC, {2'b00, 2'b00, 2'b01}, '0, '0, {C0, C0, C1}, 0);
    push("ctl10", MC, {2'b00, 2'b00, 2'b10}, '0, '0, {C0, C0, C2}, 0);
    push("ctl11", MC, {2'b00, 2'b00, 2'b11}, '0, '0, {C0, C0, C3}, 0);
    push("vff",   MV, '0, {3{8'hFF}}, '0, {3{10'h200}}, 0);

    push("data0", MD, '0, '0, {4'h0, 4'h0, 4'h0}, {3{10'b1010011100}}, 0);
    push("dataD", MD, '0, '0, {4'hD, 4'hD, 4'hD}, {3{10'b1001110001}}, 0);
    push("datam", MD, '0, '0, {4'h5, 4'hD, 4'h0},
         {10'b0100011110, 10'b1001110001, 10'b1010011100}, 0);
    push("dgb_h", MDG, {2'b00, 2'b00, 2'b01}, '0, '0, {GB, GB, 10'b1001110001}, 0);
    push("dgb_v", MDG, {2'b00, 2'b00, 2'b10}, '0, '0, {GB, GB, 10'b0101100011}, 0);

    push("v00d", MV, '0, '0, '0, {3{10'h100}}, 0);
    push("v00e", MV, '0, '0, '0, {3{10'h3FF}}, 0);
    push("ill6", 3'd6, {2'b11, 2'b10, 2'b01}, '0, '0, {C3, C2, C1}, 0);
    push("ill7", 3'd7, {2'b01, 2'b11, 2'b00}, '0, '0, {C1, C3, C0}, 0);
    push("v_after_ill", MV, '0, '0, '0, {3{10'h100}}, 0);

    // random video burst against the reference model, reset pulse mid-burst
    for (int i = 0; i < 60; i++) begin
      if (i == 30) do_reset(1);
      push($sformatf("rnd%0d", i), MV, '0,
           {8'($urandom), 8'($urandom), 8'($urandom)}, '0, '0, 1);
    end

    push("flush0", MC, '0, '0, '0, {C0, C0, C0}, 0);
    push("flush1", MC, '0, '0, '0, {C0, C0, C0}, 0);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
